// File: rtl/pll_phase_ctrl.sv
// Dynamic phase-shift sequencer for the ECP5 EHXPLLL: setup / step pulses / gaps, then waits for LOCK.
// Optional PHASELOADREG pulse after stepping is enabled with `define PLL_PHASE_LOADREG_EN.
module pll_phase_ctrl #(
  parameter int SETUP_CYC    = 4,
  parameter int PULSE_CYC    = 4,
  parameter int GAP_CYC      = 8,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_sel,
  input  logic       req_dir,
  input  logic [7:0] req_steps,
  output logic       busy,
  output logic       done,
  output logic       err,
  input  logic       pll_lock,
  output logic [1:0] PHASESEL,
  output logic       PHASEDIR,
  output logic       PHASESTEP,
  output logic       PHASELOADREG,
  output logic [2:0] dbg_state_o
);

  localparam int MAX_AB = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int MAX_CD = (GAP_CYC > LOCK_TIMEOUT) ? GAP_CYC : LOCK_TIMEOUT;
  localparam int MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW     = (MAX_P > 1) ? $clog2(MAX_P) : 1;

  localparam logic [CW-1:0] SETUP_LAST   = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] PULSE_LAST   = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST     = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SETUP     = 3'd1,
    S_PULSE     = 3'd2,
    S_GAP       = 3'd3,
`ifdef PLL_PHASE_LOADREG_EN
    S_LOAD      = 3'd5,
`endif
    S_WAIT_LOCK = 3'd4
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [7:0]      steps_q;
  logic [1:0]      sel_q;
  logic            dir_q;
  logic            ready_q;
  logic            busy_q;
  logic            done_q;
  logic            err_q;
  logic            step_q;
  logic [1:0]      sync_q;
  logic            accept;
  logic            lock_sync;

  assign accept    = req_valid && ready_q;
  assign lock_sync = sync_q[1];

  // Two-flop synchronizer: LOCK comes straight from the PLL, unrelated to clk.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= 2'b00;
    else          sync_q <= {sync_q[0], pll_lock};
  end

`ifdef PLL_PHASE_LOADREG_EN
  logic loadreg_q;
  logic load_ph_q;
  assign PHASELOADREG = loadreg_q;
`else
  assign PHASELOADREG = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      steps_q   <= 8'd0;
      sel_q     <= 2'd0;
      dir_q     <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      step_q    <= 1'b1;
`ifdef PLL_PHASE_LOADREG_EN
      loadreg_q <= 1'b1;
      load_ph_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          ready_q <= 1'b1;
          if (accept) begin
            sel_q   <= req_sel;
            dir_q   <= req_dir;
            steps_q <= req_steps;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            if (req_steps != 8'd0) begin
              state_q <= S_SETUP;
            end else begin
`ifdef PLL_PHASE_LOADREG_EN
              state_q   <= S_LOAD;
              loadreg_q <= 1'b0;
              load_ph_q <= 1'b0;
`else
              state_q <= S_WAIT_LOCK;
`endif
            end
          end
        end
        S_SETUP: begin
          if (cnt_q == SETUP_LAST) begin
            cnt_q   <= '0;
            step_q  <= 1'b0;
            state_q <= S_PULSE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_PULSE: begin
          if (cnt_q == PULSE_LAST) begin
            cnt_q   <= '0;
            step_q  <= 1'b1;
            state_q <= S_GAP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_GAP: begin
          if (cnt_q == GAP_LAST) begin
            cnt_q   <= '0;
            steps_q <= steps_q - 8'd1;
            if (steps_q != 8'd1) begin
              step_q  <= 1'b0;
              state_q <= S_PULSE;
            end else begin
`ifdef PLL_PHASE_LOADREG_EN
              state_q   <= S_LOAD;
              loadreg_q <= 1'b0;
              load_ph_q <= 1'b0;
`else
              state_q <= S_WAIT_LOCK;
`endif
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`ifdef PLL_PHASE_LOADREG_EN
        // Low phase of PULSE_CYC, then high recovery of GAP_CYC before waiting on lock.
        S_LOAD: begin
          if (!load_ph_q) begin
            if (cnt_q == PULSE_LAST) begin
              cnt_q     <= '0;
              loadreg_q <= 1'b1;
              load_ph_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end else if (cnt_q == GAP_LAST) begin
            cnt_q     <= '0;
            load_ph_q <= 1'b0;
            state_q   <= S_WAIT_LOCK;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`endif
        S_WAIT_LOCK: begin
          if (lock_sync) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (cnt_q == TIMEOUT_LAST) begin
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          ready_q <= 1'b0;
          step_q  <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready   = ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign PHASESEL    = sel_q;
  assign PHASEDIR    = dir_q;
  assign PHASESTEP   = step_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Bench for pll_phase_ctrl: directed scenarios plus random requests against a timing-formula model.
`timescale 1ns/1ps
module tb_pll_phase_ctrl;

  localparam int S   = 4;
  localparam int P   = 4;
  localparam int G   = 8;
  localparam int L   = 1024;
  localparam int PER = P + G;
`ifdef PLL_PHASE_LOADREG_EN
  localparam bit LOADREG = 1'b1;
`else
  localparam bit LOADREG = 1'b0;
`endif

  // clock / reset
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       req_valid = 1'b0;
  logic [1:0] req_sel = 2'd0;
  logic       req_dir = 1'b0;
  logic [7:0] req_steps = 8'd0;
  logic       pll_lock = 1'b1;
  logic       req_ready, busy, done, err;
  logic [1:0] PHASESEL;
  logic       PHASEDIR, PHASESTEP, PHASELOADREG;
  logic [2:0] dbg_state_o;

  always #5 clk = ~clk;

  pll_phase_ctrl #(.SETUP_CYC(S), .PULSE_CYC(P), .GAP_CYC(G), .LOCK_TIMEOUT(L)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_sel(req_sel), .req_dir(req_dir), .req_steps(req_steps),
    .busy(busy), .done(done), .err(err), .pll_lock(pll_lock),
    .PHASESEL(PHASESEL), .PHASEDIR(PHASEDIR), .PHASESTEP(PHASESTEP),
    .PHASELOADREG(PHASELOADREG), .dbg_state_o(dbg_state_o)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // event monitor: values after posedge number cyc are seen at the following negedge
  int   fall_log[$], len_log[$], done_log[$], ldfall_log[$], ldlen_log[$];
  logic err_log[$];
  logic prev_step = 1'b1, prev_ld = 1'b1;
  int   low_len = 0, ld_len = 0, sel_bad = 0;
  logic [1:0] exp_sel = 2'd0;
  logic       exp_dir = 1'b0;

  always @(negedge clk) begin
    if (prev_step && !PHASESTEP) fall_log.push_back(cyc);
    if (PHASESTEP && low_len != 0) len_log.push_back(low_len);
    low_len <= !PHASESTEP ? low_len + 1 : 0;
    prev_step <= PHASESTEP;
    if (prev_ld && !PHASELOADREG) ldfall_log.push_back(cyc);
    if (PHASELOADREG && ld_len != 0) ldlen_log.push_back(ld_len);
    ld_len <= !PHASELOADREG ? ld_len + 1 : 0;
    prev_ld <= PHASELOADREG;
    if (done) begin
      done_log.push_back(cyc);
      err_log.push_back(err);
    end
    if (busy && (PHASESEL !== exp_sel || PHASEDIR !== exp_dir)) sel_bad <= sel_bad + 1;
  end

  // scoreboard
  int n_chk = 0, n_fail = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    @(posedge clk); #1;
    fall_log.delete(); len_log.delete(); done_log.delete(); err_log.delete();
    ldfall_log.delete(); ldlen_log.delete();
    sel_bad = 0;
  endtask

  // driver tasks
  task automatic send(input logic [1:0] s, input logic d, input logic [7:0] n, output int ta);
    int w = 0;
    @(negedge clk);
    while (!req_ready && w < 3000) begin @(negedge clk); w++; end
    chk("ready_wait", w < 3000, 1);
    req_sel = s; req_dir = d; req_steps = n; req_valid = 1'b1;
    exp_sel = s; exp_dir = d;
    ta = cyc + 1;
    @(negedge clk); #1;
    req_valid = 1'b0;
    chk("busy_after_accept", busy, 1);
    chk("ready_after_accept", req_ready, 0);
    chk("err_cleared", err, 0);
  endtask

  task automatic wait_done(input int budget);
    int w = 0;
    while (done_log.size() == 0 && w < budget) begin @(negedge clk); #1; w++; end
    chk("done_seen", done_log.size() != 0, 1);
    repeat (3) begin @(negedge clk); #1; end
  endtask

  // model: timing follows directly from the setup/pulse/gap/timeout rules
  task automatic check_run(input string tag, input int ta, input int n, input bit lock);
    int t_wait, t_done;
    t_wait = ta + ((n != 0) ? S + n * PER : 0) + (LOADREG ? PER : 0);
    t_done = t_wait + (lock ? 1 : L);
    exp_q.delete();
    for (int k = 0; k < n; k++) exp_q.push_back(32'(ta + S + k * PER));
    chk({tag, "_pulse_count"}, fall_log.size(), exp_q.size());
    for (int k = 0; k < n && k < fall_log.size(); k++) begin
      chk({tag, "_fall_time"}, fall_log[k], exp_q[k]);
      if (k < len_log.size()) chk({tag, "_pulse_len"}, len_log[k], P);
    end
    chk({tag, "_done_count"}, done_log.size(), 1);
    if (done_log.size() != 0) begin
      chk({tag, "_done_time"}, done_log[0], t_done);
      chk({tag, "_err"}, err_log[0], !lock);
    end
    chk({tag, "_ld_count"}, ldfall_log.size(), LOADREG ? 1 : 0);
    if (LOADREG && ldfall_log.size() != 0) begin
      chk({tag, "_ld_time"}, ldfall_log[0], t_wait - PER);
      if (ldlen_log.size() != 0) chk({tag, "_ld_len"}, ldlen_log[0], P);
    end
    chk({tag, "_sel_stable"}, sel_bad, 0);
    chk({tag, "_sel_idle"}, {PHASESEL, PHASEDIR}, {exp_sel, exp_dir});
    chk({tag, "_busy_end"}, busy, 0);
    chk({tag, "_ready_end"}, req_ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ta, w, n;
    bit lk;
    logic [1:0] s;
    logic d;

    // reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_step", PHASESTEP, 1);
    chk("rst_ldreg", PHASELOADREG, 1);
    chk("rst_sel", {PHASESEL, PHASEDIR}, 0);
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk); #1;
    chk("rel_ready", req_ready, 1);
    clear_logs();
    repeat (20) @(negedge clk);
    #1;
    chk("idle_no_done", done_log.size(), 0);
    chk("idle_no_pulse", fall_log.size(), 0);
    chk("idle_step", PHASESTEP, 1);
    chk("idle_busy", busy, 0);

    // directed: sel=2 dir=1 steps=3, lock held
    clear_logs();
    send(2'd2, 1'b1, 8'd3, ta);
    wait_done(200);
    check_run("three_steps", ta, 3, 1'b1);

    // zero steps
    clear_logs();
    send(2'd1, 1'b0, 8'd0, ta);
    wait_done(100);
    check_run("zero_steps", ta, 0, 1'b1);

    // lock timeout, then err sticky until next accept
    pll_lock = 1'b0;
    repeat (3) @(negedge clk);
    clear_logs();
    send(2'd3, 1'b0, 8'd1, ta);
    wait_done(L + 200);
    check_run("timeout", ta, 1, 1'b0);
    repeat (5) @(negedge clk);
    #1;
    chk("err_sticky", err, 1);
    pll_lock = 1'b1;
    repeat (3) @(negedge clk);
    clear_logs();
    send(2'd0, 1'b1, 8'd2, ta);
    wait_done(200);
    check_run("after_timeout", ta, 2, 1'b1);

    // request during PULSE is ignored
    clear_logs();
    send(2'd1, 1'b1, 8'd2, ta);
    w = 0;
    while (PHASESTEP && w < 100) begin @(negedge clk); w++; end
    chk("pulse_reached", w < 100, 1);
    req_sel = 2'd3; req_dir = 1'b0; req_steps = 8'd7; req_valid = 1'b1;
    @(negedge clk); req_valid = 1'b0;
    wait_done(200);
    check_run("ignored_req", ta, 2, 1'b1);

    // reset during the 2nd pulse of a 5-step request
    clear_logs();
    send(2'd2, 1'b0, 8'd5, ta);
    w = 0;
    while (fall_log.size() < 2 && w < 200) begin @(negedge clk); #1; w++; end
    chk("second_pulse", fall_log.size(), 2);
    chk("second_pulse_low", PHASESTEP, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_step", PHASESTEP, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    clear_logs();
    @(negedge clk); reset_n = 1'b1;
    repeat (200) @(negedge clk);
    #1;
    chk("postrst_no_pulse", fall_log.size(), 0);
    chk("postrst_no_done", done_log.size(), 0);
    chk("postrst_ready", req_ready, 1);
    chk("postrst_sel", {PHASESEL, PHASEDIR}, 0);

    // random requests
    for (int i = 0; i < 8; i++) begin
      n  = $urandom_range(0, 6);
      s  = 2'($urandom_range(0, 3));
      d  = 1'($urandom_range(0, 1));
      lk = ($urandom_range(0, 4) != 0);
      pll_lock = lk;
      repeat (3) @(negedge clk);
      clear_logs();
      send(s, d, 8'(n), ta);
      wait_done(S + n * PER + PER + L + 50);
      check_run("random", ta, n, lk);
    end
    pll_lock = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
